// File: rtl/mips_isa_pkg.sv
// MIPS ISA definitions shared by instruction_encode and instruction_decode:
// operation enum, opcode/funct fields, error codes and word-building helpers.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_ADDI  = 5'd7,
    OP_ADDIU = 5'd8,
    OP_ANDI  = 5'd9,
    OP_ORI   = 5'd10,
    OP_LUI   = 5'd11,
    OP_LW    = 5'd12,
    OP_SW    = 5'd13,
    OP_BEQ   = 5'd14,
    OP_BNE   = 5'd15,
    OP_J     = 5'd16,
    OP_JAL   = 5'd17
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL_OP   = 2'd1;
  localparam logic [1:0] ERR_BRANCH_RANGE = 2'd2;
  localparam logic [1:0] ERR_JUMP_TARGET  = 2'd3;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] adr);
    return {opc, adr};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: op + fields + pc -> machine word and error flags.
// Range/alignment checks are built only with INSTR_ENC_RANGE_CHECK_EN defined.
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] target,
  input  logic [31:0] pc,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err,
  output logic [1:0]  range_code
);

  logic [31:0] pc4;
  logic [31:0] diff;
  logic [31:0] off;
  logic        is_branch;
  logic        is_jump;

  // Branch offsets are relative to the delay-slot address, in words.
  assign pc4  = pc + 32'd4;
  assign diff = target - pc4;
  assign off  = 32'($signed(diff) >>> 2);

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    word      = '0;
    illegal   = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (op)
      OP_ADD:   word = enc_r(rs, rt, rd, shamt, FUNCT_ADD);
      OP_ADDU:  word = enc_r(rs, rt, rd, shamt, FUNCT_ADDU);
      OP_SUB:   word = enc_r(rs, rt, rd, shamt, FUNCT_SUB);
      OP_AND:   word = enc_r(rs, rt, rd, shamt, FUNCT_AND);
      OP_OR:    word = enc_r(rs, rt, rd, shamt, FUNCT_OR);
      OP_SLL:   word = enc_r(5'd0, rt, rd, shamt, FUNCT_SLL);
      OP_SRL:   word = enc_r(5'd0, rt, rd, shamt, FUNCT_SRL);
      OP_ADDI:  word = enc_i(OPC_ADDI, rs, rt, imm);
      OP_ADDIU: word = enc_i(OPC_ADDIU, rs, rt, imm);
      OP_ANDI:  word = enc_i(OPC_ANDI, rs, rt, imm);
      OP_ORI:   word = enc_i(OPC_ORI, rs, rt, imm);
      OP_LUI:   word = enc_i(OPC_LUI, 5'd0, rt, imm);
      OP_LW:    word = enc_i(OPC_LW, rs, rt, imm);
      OP_SW:    word = enc_i(OPC_SW, rs, rt, imm);
      OP_BEQ: begin
        word      = enc_i(OPC_BEQ, rs, rt, off[15:0]);
        is_branch = 1'b1;
      end
      OP_BNE: begin
        word      = enc_i(OPC_BNE, rs, rt, off[15:0]);
        is_branch = 1'b1;
      end
      OP_J: begin
        word    = enc_j(OPC_J, target[27:2]);
        is_jump = 1'b1;
      end
      OP_JAL: begin
        word    = enc_j(OPC_JAL, target[27:2]);
        is_jump = 1'b1;
      end
      default:  illegal = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic off_ovf;
  logic misaligned;
  logic region_bad;

  // The word offset fits 16 bits only if bits 31..15 are a pure sign extension.
  assign off_ovf    = !((&off[31:15]) | ~(|off[31:15]));
  assign misaligned = |target[1:0];
  assign region_bad = target[31:28] != pc4[31:28];

  always_comb begin
    range_err  = 1'b0;
    range_code = ERR_NONE;
    if (is_branch && (off_ovf || misaligned)) begin
      range_err  = 1'b1;
      range_code = ERR_BRANCH_RANGE;
    end else if (is_jump && (region_bad || misaligned)) begin
      range_err  = 1'b1;
      range_code = ERR_JUMP_TARGET;
    end
  end
`else
  logic unused_range;

  assign range_err    = 1'b0;
  assign range_code   = ERR_NONE;
  assign unused_range = ^{off[31:16], is_branch, is_jump};
`endif

endmodule

// File: rtl/instruction_encode.sv
// Streaming MIPS instruction encoder: owns pc, word count, output register and
// handshake. INSTR_ENC_RANGE_CHECK_EN enables branch/jump target checking.
module instruction_encode
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_op,
  input  logic [4:0]                   in_rs,
  input  logic [4:0]                   in_rt,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_shamt,
  input  logic [15:0]                  in_imm,
  input  logic [31:0]                  in_target,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_word,
  output logic [31:0]                  out_addr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         err,
  output logic [1:0]                   err_code
);

  localparam int CW = $clog2(DEPTH+1);

  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_word_q,  out_word_d;
  logic [31:0]   out_addr_q,  out_addr_d;
  logic [31:0]   pc_q,        pc_d;
  logic [CW-1:0] count_q,     count_d;
  logic          err_q,       err_d;
  logic [1:0]    err_code_q,  err_code_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        pack_range_err;
  logic [1:0]  pack_range_code;
  logic        accept;

  instr_field_pack u_pack (
    .op         (in_op),
    .rs         (in_rs),
    .rt         (in_rt),
    .rd         (in_rd),
    .shamt      (in_shamt),
    .imm        (in_imm),
    .target     (in_target),
    .pc         (pc_q),
    .word       (pack_word),
    .illegal    (pack_illegal),
    .range_err  (pack_range_err),
    .range_code (pack_range_code)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !rst && !start && !full && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    pc_d        = pc_q;
    count_d     = count_q;
    err_d       = err_q;
    err_code_d  = err_code_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // Rejected instructions are still consumed; only the first error code sticks.
    if (accept) begin
      if (pack_illegal) begin
        err_d = 1'b1;
        if (err_code_q == ERR_NONE) err_code_d = ERR_ILLEGAL_OP;
      end else if (pack_range_err) begin
        err_d = 1'b1;
        if (err_code_q == ERR_NONE) err_code_d = pack_range_code;
      end else begin
        out_valid_d = 1'b1;
        out_word_d  = pack_word;
        out_addr_d  = pc_q;
        pc_d        = pc_q + 32'd4;
        count_d     = count_q + CW'(1);
      end
    end

    if (start) begin
      out_valid_d = 1'b0;
      out_word_d  = '0;
      out_addr_d  = '0;
      pc_d        = BASE_ADDR;
      count_d     = '0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      pc_q        <= BASE_ADDR;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_instruction_encode.sv
// Self-checking bench for instruction_encode: directed cases from the ISA rules
// plus randomized traffic checked against a transaction-level reference model.
module tb_instruction_encode;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_valid, out_ready, full, err;
  logic [4:0]    in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [31:0]   in_target, out_word, out_addr;
  logic [CW-1:0] count;
  logic [1:0]    err_code;

  instruction_encode #(.BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .count(count), .full(full),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { bit [31:0] word; bit [31:0] addr; } exp_t;

  exp_t      exp_q[$];
  bit [31:0] m_pc;
  int        m_count, m_code, n_checks, n_errors;
  bit        m_err;

  int opc_tab [18] = '{'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h08, 'h09,
                       'h0C, 'h0D, 'h0F, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h03};
  int fn_tab  [7]  = '{'h20, 'h21, 'h22, 'h24, 'h25, 'h00, 'h02};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: fields placed by arithmetic; code 0 ok, 1..3 as err_code.
  function automatic void ref_encode(input int op, input int rs, input int rt, input int rd,
                                     input int sh, input int imm, input bit [31:0] target,
                                     input bit [31:0] pc, output bit [31:0] w, output int code);
    bit [31:0] pc4, opc;
    int        d, off;
    w    = 0;
    code = 0;
    pc4  = pc + 4;
    if (op > 17) begin
      code = 1;
      return;
    end
    opc = opc_tab[op];
    if (op <= 6) begin
      w = ((op == 5 || op == 6) ? 0 : rs) * (2 ** 21) + rt * (2 ** 16) + rd * (2 ** 11)
          + sh * (2 ** 6) + fn_tab[op];
    end else if (op <= 13) begin
      w = (opc << 26) + ((op == 11) ? 0 : rs) * (2 ** 21) + rt * (2 ** 16) + imm;
    end else if (op <= 15) begin
      d   = int'(target - pc4);
      off = d >>> 2;
      if (RC && (off < -32768 || off > 32767 || target % 4 != 0)) code = 2;
      w = (opc << 26) + rs * (2 ** 21) + rt * (2 ** 16) + (off & 'hFFFF);
    end else begin
      if (RC && ((target >> 28) != (pc4 >> 28) || target % 4 != 0)) code = 3;
      w = (opc << 26) + ((target >> 2) & 'h3FF_FFFF);
    end
  endfunction

  // Called at a negedge with inputs set for the coming posedge.
  task automatic step();
    bit [31:0] w;
    int        code;
    bit        exp_rdy, acc;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_word", out_word, exp_q[0].word);
      check("out_addr", out_addr, exp_q[0].addr);
    end
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
    #1;
    exp_rdy = !start && (m_count != DEPTH) && (exp_q.size() == 0 || out_ready);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (start) begin
      exp_q.delete();
      m_pc = 0; m_count = 0; m_err = 0; m_code = 0;
    end else begin
      acc = in_valid && exp_rdy;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        ref_encode(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_shamt),
                   int'(in_imm), in_target, m_pc, w, code);
        if (code != 0) begin
          m_err = 1;
          if (m_code == 0) m_code = code;
        end else begin
          exp_q.push_back('{word: w, addr: m_pc});
          m_pc    = m_pc + 4;
          m_count = m_count + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input int op, input int rs, input int rt, input int rd,
                       input bit [15:0] imm, input bit [31:0] target);
    in_op = op[4:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
    in_shamt = 5'd0; in_imm = imm; in_target = target; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; in_valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    m_pc = 0; m_count = 0; m_err = 0; m_code = 0; n_checks = 0; n_errors = 0;
    repeat (3) @(negedge clk);
    check("rdy_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    check("rst_word", out_word, 32'h0);
    check("rst_addr", out_addr, 32'h0);
    step();

    // Directed encodings from a fresh program.
    issue(0, 1, 2, 3, 16'h0, 32'h0);
    check("add_word", out_word, 32'h0022_1820);
    check("add_addr", out_addr, 32'h0);
    check("add_count", 32'(count), 32'd1);
    issue(7, 0, 8, 0, 16'h0005, 32'h0);
    check("addi_word", out_word, 32'h2008_0005);
    issue(14, 1, 0, 0, 16'h0, 32'h0);
    check("beq_word", out_word, 32'h1020_FFFD);
    check("beq_addr", out_addr, 32'h8);
    do_start();
    issue(16, 0, 0, 0, 16'h0, 32'h0040_0018);
    check("j_word", out_word, 32'h0810_0006);

    // Backpressure: held word, in_ready low, nothing lost.
    out_ready = 1'b0;
    in_op = 5'd1; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6; in_valid = 1'b1;
    repeat (3) begin
      step();
      check("bp_hold", out_word, 32'h0810_0006);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();

    // Fill to DEPTH; in_ready must stay low afterwards.
    do_start();
    for (int i = 0; i < DEPTH; i++) issue(1, i, i + 1, i + 2, 16'h0, 32'h0);
    in_valid = 1'b1;
    repeat (3) step();
    check("full_lit", 32'(full), 32'd1);
    check("full_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Illegal op, then first-error retention and start clearing.
    do_start();
    issue(20, 1, 2, 3, 16'h0, 32'h0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_code", 32'(err_code), 32'd1);
    check("ill_noout", 32'(out_valid), 32'd0);
    issue(0, 1, 2, 3, 16'h0, 32'h0);
    check("ill_pc", out_addr, 32'h0);
    issue(14, 1, 0, 0, 16'h0, 32'h0004_0000);
    check("first_err_kept", 32'(err_code), 32'd1);
    do_start();
    check("start_err", 32'(err), 32'd0);
    issue(14, 1, 0, 0, 16'h0, 32'h0004_0000);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    check("range_code", 32'(err_code), 32'd2);
`else
    check("trunc_word", out_word, 32'h1020_FFFF);
`endif

    // Randomized traffic against the reference model.
    repeat (3000) begin
      int r;
      start     = (m_count == DEPTH) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 19);
      in_op    = (r < 18) ? 5'(r) : 5'($urandom_range(18, 31));
      in_rs    = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      in_shamt = 5'($urandom); in_imm = 16'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        in_target = $urandom;
      end else if (in_op == 5'd16 || in_op == 5'd17) begin
        in_target = ((m_pc + 4) & 32'hF000_0000) | ($urandom & 32'h0FFF_FFFC);
      end else begin
        in_target = m_pc + 4 + 32'($urandom_range(0, 400)) * 4 - 32'd800;
      end
      step();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
